// File: rtl/pcpu_run_ctrl_if.sv
// Host/controller bundle for pcpu_run_ctrl: command pulses, program-load
// stream, instruction-memory write port, CPU control and status.
interface pcpu_run_ctrl_if #(
  parameter int IW = 16,
  parameter int AW = 8,
  parameter int CW = 32
);
  logic          cmd_load;
  logic          cmd_go;
  logic          cmd_abort;
  logic          ld_valid;
  logic          ld_ready;
  logic [IW-1:0] ld_data;
  logic          ld_last;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [IW-1:0] im_data;
  logic          cpu_enable;
  logic          cpu_start;
  logic [IW-1:0] cpu_ir;
  logic          busy;
  logic          done;
  logic          timeout;
  logic          load_full;
  logic [AW:0]   words_loaded;
  logic [CW-1:0] cycles;

  // Host / driver side.
  modport master (
    output cmd_load, cmd_go, cmd_abort, ld_valid, ld_data, ld_last, cpu_ir,
    input  ld_ready, im_we, im_addr, im_data, cpu_enable, cpu_start,
           busy, done, timeout, load_full, words_loaded, cycles
  );

  // Run controller side.
  modport slave (
    input  cmd_load, cmd_go, cmd_abort, ld_valid, ld_data, ld_last, cpu_ir,
    output ld_ready, im_we, im_addr, im_data, cpu_enable, cpu_start,
           busy, done, timeout, load_full, words_loaded, cycles
  );
endinterface

// File: rtl/pcpu_run_ctrl.sv
// Run controller for the pipelined CPU. Streams a program into instruction
// memory, then arms the CPU, pulses start, counts RUN cycles and stops on a
// HALT opcode in the decode stage or when the watchdog limit is reached.
// All outputs are registered and derived from the next state.
module pcpu_run_ctrl #(
  parameter int             IW        = 16,
  parameter int             AW        = 8,
  parameter int             OPW       = 5,
  parameter logic [OPW-1:0] HALT_OP   = 5'b00001,
  parameter int             ARM_CYC   = 2,
  parameter int             START_LEN = 1,
  parameter int             CW        = 32,
  parameter int             MAX_CYC   = 1000
) (
  input logic              clock,
  input logic              reset,
  pcpu_run_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARM, S_START, S_RUN, S_DONE, S_TMO
  } state_t;

  localparam int PMAX = (ARM_CYC > START_LEN) ? ARM_CYC : START_LEN;
  localparam int PW   = $clog2(PMAX + 1);

  localparam logic [PW-1:0] ARM_LAST   = PW'(ARM_CYC - 1);
  localparam logic [PW-1:0] START_LAST = PW'(START_LEN - 1);
  localparam logic [AW:0]   LAST_ADDR  = {1'b0, {AW{1'b1}}};
  localparam logic [CW-1:0] MAX_CYC_W  = CW'(MAX_CYC);

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          ld_ready_q, ld_ready_d;
  logic          im_we_q, im_we_d;
  logic [AW-1:0] im_addr_q, im_addr_d;
  logic [IW-1:0] im_data_q, im_data_d;
  logic          cpu_enable_q, cpu_enable_d;
  logic          cpu_start_q, cpu_start_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic          load_full_q, load_full_d;
  logic [AW:0]   words_loaded_q, words_loaded_d;
  logic [CW-1:0] cycles_q, cycles_d;

  logic          halt_seen;
  assign halt_seen = (bus.cpu_ir[IW-1 -: OPW] == HALT_OP);

  // Next-state, counter and registered-output computation.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; that is what keeps this block from inferring latches.
    state_d        = state_q;
    phase_d        = phase_q;
    im_we_d        = 1'b0;
    im_addr_d      = im_addr_q;
    im_data_d      = im_data_q;
    done_d         = done_q;
    timeout_d      = timeout_q;
    load_full_d    = load_full_q;
    words_loaded_d = words_loaded_q;
    cycles_d       = cycles_q;

    if (bus.cmd_abort) begin
      state_d   = S_IDLE;
      done_d    = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_TMO: begin
          if (bus.cmd_load) begin
            state_d        = S_LOAD;
            words_loaded_d = '0;
            load_full_d    = 1'b0;
            done_d         = 1'b0;
            timeout_d      = 1'b0;
          end else if (bus.cmd_go && (words_loaded_q != '0)) begin
            state_d   = S_ARM;
            phase_d   = '0;
            cycles_d  = '0;
            done_d    = 1'b0;
            timeout_d = 1'b0;
          end
        end
        S_LOAD: begin
          if (bus.ld_valid && ld_ready_q) begin
            im_we_d        = 1'b1;
            im_addr_d      = words_loaded_q[AW-1:0];
            im_data_d      = bus.ld_data;
            words_loaded_d = words_loaded_q + (AW+1)'(1);
            if (bus.ld_last) begin
              state_d = S_IDLE;
            end else if (words_loaded_q == LAST_ADDR) begin
              // Memory is full: stop here rather than wrap to address 0.
              state_d     = S_IDLE;
              load_full_d = 1'b1;
            end
          end
        end
        S_ARM: begin
          if (phase_q == ARM_LAST) begin
            state_d = S_START;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
        S_START: begin
          if (phase_q == START_LAST) begin
            state_d  = S_RUN;
            phase_d  = '0;
            cycles_d = CW'(1);
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
        S_RUN: begin
          // HALT takes priority over the watchdog on the same cycle.
          if (halt_seen) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (cycles_q == MAX_CYC_W) begin
            state_d   = S_TMO;
            timeout_d = 1'b1;
          end else begin
            cycles_d = cycles_q + CW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    ld_ready_d   = (state_d == S_LOAD);
    cpu_start_d  = (state_d == S_START);
    cpu_enable_d = (state_d == S_ARM) || (state_d == S_START) || (state_d == S_RUN);
    busy_d       = cpu_enable_d || (state_d == S_LOAD);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      phase_q        <= '0;
      ld_ready_q     <= 1'b0;
      im_we_q        <= 1'b0;
      im_addr_q      <= '0;
      im_data_q      <= '0;
      cpu_enable_q   <= 1'b0;
      cpu_start_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
      load_full_q    <= 1'b0;
      words_loaded_q <= '0;
      cycles_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before the edge, independent of statement order.
      state_q        <= state_d;
      phase_q        <= phase_d;
      ld_ready_q     <= ld_ready_d;
      im_we_q        <= im_we_d;
      im_addr_q      <= im_addr_d;
      im_data_q      <= im_data_d;
      cpu_enable_q   <= cpu_enable_d;
      cpu_start_q    <= cpu_start_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      timeout_q      <= timeout_d;
      load_full_q    <= load_full_d;
      words_loaded_q <= words_loaded_d;
      cycles_q       <= cycles_d;
    end
  end

  assign bus.ld_ready     = ld_ready_q;
  assign bus.im_we        = im_we_q;
  assign bus.im_addr      = im_addr_q;
  assign bus.im_data      = im_data_q;
  assign bus.cpu_enable   = cpu_enable_q;
  assign bus.cpu_start    = cpu_start_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.timeout      = timeout_q;
  assign bus.load_full    = load_full_q;
  assign bus.words_loaded = words_loaded_q;
  assign bus.cycles       = cycles_q;

endmodule
